// File: rtl/user_project_mux.sv
// -----------------------------------------------------------------------------
// user_project_mux
//   Hosts N_PROJ user designs behind the Caravel IO pads and selects one at
//   run time through a Wishbone control register. A switch tri-states every
//   pad for GUARD_CYCLES, then holds the target design in reset for
//   RST_CYCLES, and only then muxes its IO onto the pads. Designs that are
//   not selected are held in reset.
//
// Ports
//   wb_clk_i, wb_rst_i      : clock shared with all hosted designs, sync reset
//   wbs_*                   : Wishbone slave (CTRL 0x00, STATUS 0x04, CFG 0x08)
//   proj_io_out/proj_io_oeb : packed per-design pad drives, design k at k*IO_W
//   proj_rst_o              : per-design active-high reset
//   io_out/io_oeb           : pad drive / output enable (1 = tristate)
//   active_o                : high while a design owns the pads
// -----------------------------------------------------------------------------
module user_project_mux #(
    parameter int unsigned N_PROJ       = 4,
    parameter int unsigned IO_W         = 38,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned RST_CYCLES   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic [N_PROJ*IO_W-1:0]   proj_io_out,
    input  logic [N_PROJ*IO_W-1:0]   proj_io_oeb,
    output logic [N_PROJ-1:0]        proj_rst_o,
    output logic [IO_W-1:0]          io_out,
    output logic [IO_W-1:0]          io_oeb,
    output logic                     active_o
);

    localparam int unsigned CntMax = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);
    localparam logic [CntW-1:0] RstLast   = CntW'(RST_CYCLES - 1);

    localparam logic [7:0] OffCtrl   = 8'h00;
    localparam logic [7:0] OffStatus = 8'h04;
    localparam logic [7:0] OffCfg    = 8'h08;

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StGuard = 2'd1,
        StReset = 2'd2,
        StRun   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      tgt_q, tgt_d;
    logic [3:0]      act_sel_q, act_sel_d;

    logic [3:0]      ctrl_sel_q, ctrl_sel_d;
    logic            ctrl_en_q, ctrl_en_d;
    logic            err_q, err_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;

    logic            hit;
    logic            wr;
    logic            ctrl_wr;
    logic            status_wr;
    logic [3:0]      wr_sel;
    logic            sel_ok;
    logic            ctrl_accept;
    logic [31:0]     rdata;

    // Bits of the bus that carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:17], wbs_dat_i[15:9], wbs_dat_i[7:4]};

    // ---------------------------------------------------------------------
    // Wishbone decode
    // ---------------------------------------------------------------------
    // ~ack_q keeps a held strobe from being taken twice in adjacent cycles.
    assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    assign wr        = hit & wbs_we_i;
    assign ctrl_wr   = wr & (wbs_adr_i[7:0] == OffCtrl) & wbs_sel_i[0];
    assign status_wr = wr & (wbs_adr_i[7:0] == OffStatus);
    assign wr_sel    = wbs_dat_i[3:0];
    assign sel_ok    = ({28'd0, wr_sel} < N_PROJ);
    assign ctrl_accept = ctrl_wr & sel_ok;

    always_comb begin
        rdata = '0;
        case (wbs_adr_i[7:0])
            OffCtrl:   rdata = {23'd0, ctrl_en_q, 4'd0, ctrl_sel_q};
            OffStatus: rdata = {15'd0, err_q, 4'd0, act_sel_q, 6'd0, state_q};
            OffCfg:    rdata = {8'd0, 8'(RST_CYCLES), 8'(GUARD_CYCLES), 8'(N_PROJ)};
            default:   rdata = '0;
        endcase
    end

    always_comb begin
        ack_d      = hit;
        dat_d      = (hit & ~wbs_we_i) ? rdata : 32'd0;
        ctrl_sel_d = ctrl_sel_q;
        ctrl_en_d  = ctrl_en_q;
        err_d      = err_q;
        if (ctrl_accept) begin
            ctrl_sel_d = wr_sel;
            ctrl_en_d  = wbs_dat_i[8];
        end
        if (ctrl_wr & ~sel_ok) begin
            err_d = 1'b1;
        end
        if (status_wr & wbs_dat_i[16]) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_sel_q <= '0;
            ctrl_en_q  <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            ctrl_sel_q <= ctrl_sel_d;
            ctrl_en_q  <= ctrl_en_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // ---------------------------------------------------------------------
    // Switch sequencer: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StOff;
            cnt_q     <= '0;
            tgt_q     <= '0;
            act_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            act_sel_q <= act_sel_d;
        end
    end

    // ---------------------------------------------------------------------
    // Switch sequencer: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        act_sel_d = act_sel_q;
        if (ctrl_accept) begin
            // A bus write always wins over the sequencer's own progress.
            if (!wbs_dat_i[8]) begin
                state_d = StOff;
            end else if (!((state_q == StRun) && (wr_sel == act_sel_q))) begin
                state_d = StGuard;
                tgt_d   = wr_sel;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                StGuard: begin
                    if (cnt_q == GuardLast) begin
                        state_d = StReset;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StReset: begin
                    if (cnt_q == RstLast) begin
                        state_d   = StRun;
                        act_sel_d = tgt_q;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Switch sequencer: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        io_out     = '0;
        io_oeb     = '1;
        proj_rst_o = '1;
        active_o   = (state_q == StRun);
        if (state_q == StRun) begin
            for (int unsigned k = 0; k < N_PROJ; k++) begin
                if ({28'd0, act_sel_q} == k) begin
                    io_out        = proj_io_out[k*IO_W +: IO_W];
                    io_oeb        = proj_io_oeb[k*IO_W +: IO_W];
                    proj_rst_o[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_user_project_mux.sv
module tb_user_project_mux;

    localparam int N  = 4;
    localparam int W  = 38;
    localparam int G  = 4;
    localparam int R  = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [W-1:0] ONES = 38'h3F_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stb = 1'b0;
    logic            cyc = 1'b0;
    logic            we = 1'b0;
    logic [3:0]      bsel = 4'h0;
    logic [31:0]     adr = 32'h0;
    logic [31:0]     wdat = 32'h0;
    logic            ack;
    logic [31:0]     rdat;
    logic [N*W-1:0]  p_out = '0;
    logic [N*W-1:0]  p_oeb = '0;
    logic [N-1:0]    p_rst;
    logic [W-1:0]    io_out;
    logic [W-1:0]    io_oeb;
    logic            active;

    int n_chk = 0;
    int n_err = 0;

    user_project_mux #(
        .N_PROJ(N), .IO_W(W), .GUARD_CYCLES(G), .RST_CYCLES(R), .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (bsel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .proj_io_out (p_out),
        .proj_io_oeb (p_oeb),
        .proj_rst_o  (p_rst),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .active_o    (active)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: the sequencer phase is derived from the time since
    // the last accepted switch request.
    // ------------------------------------------------------------------
    int          m_cyc = 0;
    bit          m_on = 0;
    int          m_start = 0;
    int          m_tgt = 0;
    int          m_act = 0;
    int          m_csel = 0;
    bit          m_cen = 0;
    bit          m_err = 0;
    bit          m_ack = 0;
    logic [31:0] m_dat = 32'h0;

    function automatic int state_at(int n);
        int e;
        if (!m_on) return 0;
        e = n - m_start;
        if (e < G) return 1;
        if (e < G + R) return 2;
        return 3;
    endfunction

    task automatic model_step();
        int st;
        bit hit;
        int off;
        int s;
        logic [31:0] rd;
        if (rst) begin
            m_cyc++;
            m_on = 0; m_tgt = 0; m_act = 0; m_csel = 0; m_cen = 0;
            m_err = 0; m_ack = 0; m_dat = 0;
            return;
        end
        st  = state_at(m_cyc);
        hit = stb && cyc && (adr[31:8] == BASE[31:8]) && !m_ack;
        off = int'(adr[7:0]);
        rd  = 0;
        m_cyc++;
        if (hit && !we) begin
            if (off == 0) rd = m_csel + (m_cen ? 32'h100 : 0);
            else if (off == 4) rd = (m_err ? 32'h10000 : 0) + m_act * 256 + st;
            else if (off == 8) rd = N + G * 256 + R * 65536;
        end
        if (hit && we) begin
            if (off == 0 && bsel[0]) begin
                s = int'(wdat[3:0]);
                if (s >= N) begin
                    m_err = 1;
                end else begin
                    m_csel = s;
                    m_cen  = wdat[8];
                    if (!wdat[8]) m_on = 0;
                    else if (!(st == 3 && s == m_act)) begin
                        m_on = 1; m_start = m_cyc; m_tgt = s;
                    end
                end
            end else if (off == 4 && wdat[16]) begin
                m_err = 0;
            end
        end
        if (state_at(m_cyc) == 3) m_act = m_tgt;
        m_ack = hit;
        m_dat = rd;
    endtask

    // Cycle-by-cycle scoreboard of every DUT output.
    always @(posedge clk) begin
        logic [W-1:0] e_out;
        logic [W-1:0] e_oeb;
        logic [N-1:0] e_rst;
        bit run;
        model_step();
        #1;
        run   = (state_at(m_cyc) == 3);
        e_out = run ? p_out[m_act*W +: W] : '0;
        e_oeb = run ? p_oeb[m_act*W +: W] : ONES;
        e_rst = '1;
        if (run) e_rst[m_act] = 1'b0;
        n_chk += 6;
        if (ack !== m_ack) begin
            n_err++; $display("FAIL mon_ack cyc=%0d got %b want %b", m_cyc, ack, m_ack);
        end
        if (rdat !== m_dat) begin
            n_err++; $display("FAIL mon_dat cyc=%0d got %h want %h", m_cyc, rdat, m_dat);
        end
        if (io_out !== e_out) begin
            n_err++; $display("FAIL mon_io_out cyc=%0d got %h want %h", m_cyc, io_out, e_out);
        end
        if (io_oeb !== e_oeb) begin
            n_err++; $display("FAIL mon_io_oeb cyc=%0d got %h want %h", m_cyc, io_oeb, e_oeb);
        end
        if (p_rst !== e_rst) begin
            n_err++; $display("FAIL mon_rst cyc=%0d got %b want %b", m_cyc, p_rst, e_rst);
        end
        if (active !== run) begin
            n_err++; $display("FAIL mon_active cyc=%0d got %b want %b", m_cyc, active, run);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only; checks live in the test tasks)
    // ------------------------------------------------------------------
    task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, output logic got_ack,
                             output logic [31:0] got_dat);
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = a; wdat = d; bsel = s;
        @(negedge clk);
        got_ack = ack; got_dat = rdat;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wait_until(input int n);
        while (m_cyc < n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic a; logic [31:0] d;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        n_chk += 4;
        if (io_oeb !== ONES) begin n_err++; $display("FAIL reset_oeb got %h want %h", io_oeb, ONES); end
        if (io_out !== '0) begin n_err++; $display("FAIL reset_out got %h want 0", io_out); end
        if (p_rst !== 4'hF) begin n_err++; $display("FAIL reset_rst got %b want 1111", p_rst); end
        if (active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b want 0", active); end
        wb_access(BASE + 4, 0, 0, 4'hF, a, d);
        n_chk += 2;
        if (a !== 1'b1) begin n_err++; $display("FAIL reset_status_ack got %b want 1", a); end
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_status got %h want 0", d); end
        wb_access(BASE + 8, 0, 0, 4'hF, a, d);
        n_chk++;
        if (d !== 32'h0008_0404) begin n_err++; $display("FAIL cfg got %h want 00080404", d); end
    endtask

    task automatic test_select();
        logic a; logic [31:0] d; int e;
        p_out[2*W +: W] = 38'h15_5555_5555;
        p_oeb[2*W +: W] = '0;
        wb_access(BASE, 1, 32'h102, 4'hF, a, d);
        e = m_cyc;
        n_chk++;
        if (a !== 1'b1) begin n_err++; $display("FAIL sel_ack got %b want 1", a); end
        wb_access(BASE + 4, 0, 0, 4'hF, a, d);
        n_chk++;
        if (d[1:0] !== 2'd1) begin n_err++; $display("FAIL sel_guard got %0d want 1", d[1:0]); end
        wait_until(e + 6);
        wb_access(BASE + 4, 0, 0, 4'hF, a, d);
        n_chk++;
        if (d[1:0] !== 2'd2) begin n_err++; $display("FAIL sel_resetph got %0d want 2", d[1:0]); end
        wait_until(e + 11);
        n_chk++;
        if (active !== 1'b0) begin n_err++; $display("FAIL sel_early got %b want 0", active); end
        wait_until(e + 12);
        n_chk += 4;
        if (active !== 1'b1) begin n_err++; $display("FAIL sel_run got %b want 1", active); end
        if (p_rst !== 4'b1011) begin n_err++; $display("FAIL sel_rst got %b want 1011", p_rst); end
        if (io_out !== 38'h15_5555_5555) begin
            n_err++; $display("FAIL sel_out got %h want 1555555555", io_out);
        end
        if (io_oeb !== '0) begin n_err++; $display("FAIL sel_oeb got %h want 0", io_oeb); end
        wb_access(BASE + 4, 0, 0, 4'hF, a, d);
        n_chk++;
        if (d !== 32'h203) begin n_err++; $display("FAIL sel_status got %h want 203", d); end
    endtask

    task automatic test_switch();
        logic a; logic [31:0] d; int e;
        p_out[1*W +: W] = 38'h2A_AAAA_AAAA;
        p_oeb[1*W +: W] = 38'h0F_0F0F_0F0F;
        wb_access(BASE, 1, 32'h101, 4'hF, a, d);
        e = m_cyc;
        n_chk += 2;
        if (io_oeb !== ONES) begin n_err++; $display("FAIL sw_oeb got %h want all ones", io_oeb); end
        if (p_rst !== 4'hF) begin n_err++; $display("FAIL sw_rst got %b want 1111", p_rst); end
        wait_until(e + 12);
        n_chk += 3;
        if (p_rst !== 4'b1101) begin n_err++; $display("FAIL sw_run_rst got %b want 1101", p_rst); end
        if (io_out !== 38'h2A_AAAA_AAAA) begin
            n_err++; $display("FAIL sw_out got %h want 2aaaaaaaaa", io_out);
        end
        if (io_oeb !== 38'h0F_0F0F_0F0F) begin
            n_err++; $display("FAIL sw_oeb_run got %h want 0f0f0f0f0f", io_oeb);
        end
    endtask

    task automatic test_invalid_sel();
        logic a; logic [31:0] d;
        wb_access(BASE, 1, 32'h107, 4'hF, a, d);
        n_chk++;
        if (a !== 1'b1) begin n_err++; $display("FAIL inv_ack got %b want 1", a); end
        wb_access(BASE + 4, 0, 0, 4'hF, a, d);
        n_chk++;
        if (d !== 32'h1_0103) begin n_err++; $display("FAIL inv_status got %h want 10103", d); end
        wb_access(BASE, 0, 0, 4'hF, a, d);
        n_chk++;
        if (d !== 32'h101) begin n_err++; $display("FAIL inv_ctrl got %h want 101", d); end
        wb_access(BASE + 4, 1, 32'h1_0000, 4'hF, a, d);
        wb_access(BASE + 4, 0, 0, 4'hF, a, d);
        n_chk++;
        if (d !== 32'h103) begin n_err++; $display("FAIL err_clear got %h want 103", d); end
    endtask

    task automatic test_restart();
        logic a; logic [31:0] d; int e0; int e1;
        wb_access(BASE, 1, 32'h102, 4'hF, a, d);
        e0 = m_cyc;
        wait_until(e0 + 8);
        // Hit edge lands with the reset phase counter at 5.
        wb_access(BASE, 1, 32'h103, 4'hF, a, d);
        e1 = m_cyc;
        while (m_cyc < e1 + 11) begin
            n_chk++;
            if (p_rst[2:0] !== 3'b111 || active !== 1'b0) begin
                n_err++; $display("FAIL restart_hold cyc=%0d rst=%b active=%b", m_cyc, p_rst, active);
            end
            @(negedge clk);
        end
        n_chk += 2;
        if (active !== 1'b0) begin n_err++; $display("FAIL restart_early got %b want 0", active); end
        wait_until(e1 + 12);
        if (p_rst !== 4'b0111 || active !== 1'b1) begin
            n_err++; $display("FAIL restart_run rst=%b active=%b want 0111/1", p_rst, active);
        end
    endtask

    task automatic test_bus_reset();
        logic a; logic [31:0] d;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_chk += 4;
        if (io_oeb !== ONES) begin n_err++; $display("FAIL brst_oeb got %h want all ones", io_oeb); end
        if (p_rst !== 4'hF) begin n_err++; $display("FAIL brst_rst got %b want 1111", p_rst); end
        if (active !== 1'b0) begin n_err++; $display("FAIL brst_active got %b want 0", active); end
        if (io_out !== '0) begin n_err++; $display("FAIL brst_out got %h want 0", io_out); end
        wb_access(BASE, 0, 0, 4'hF, a, d);
        n_chk++;
        if (d !== 32'h0) begin n_err++; $display("FAIL brst_ctrl got %h want 0", d); end
        wb_access(BASE + 32'hC, 0, 0, 4'hF, a, d);
        n_chk += 2;
        if (a !== 1'b1) begin n_err++; $display("FAIL unmapped_ack got %b want 1", a); end
        if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_dat got %h want 0", d); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = BASE + 8; bsel = 4'hF;
        repeat (4) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        stb = 0; cyc = 0;
        n_chk++;
        if (acks != 2) begin n_err++; $display("FAIL b2b_acks got %0d want 2", acks); end
        // Neighbouring 256-byte window must be ignored.
        @(negedge clk);
        stb = 1; cyc = 1; we = 1; adr = BASE + 32'h100; wdat = 32'h101; bsel = 4'hF;
        @(negedge clk);
        stb = 0; cyc = 0; we = 0;
        n_chk++;
        if (ack !== 1'b0) begin n_err++; $display("FAIL nomatch_ack got %b want 0", ack); end
    endtask

    task automatic test_random();
        logic a; logic [31:0] d; logic [31:0] x; int r;
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                x = $urandom;
                x[3:0] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 5));
                x[8]   = ($urandom_range(0, 3) != 0);
                wb_access(BASE, 1, x, ($urandom_range(0, 7) == 0) ? 4'hE : 4'hF, a, d);
            end else if (r < 58) begin
                wb_access(BASE + 4, 1, $urandom, 4'hF, a, d);
            end else if (r < 75) begin
                wb_access(BASE + 32'($urandom_range(0, 3) * 4), 0, 0, 4'hF, a, d);
            end else if (r < 83) begin
                wb_access(($urandom_range(0, 1) == 0) ? 32'h4000_0000 : BASE + 32'h200,
                          1'($urandom_range(0, 1)), 32'h101, 4'hF, a, d);
                n_chk++;
                if (a !== 1'b0) begin n_err++; $display("FAIL rnd_nomatch_ack got %b want 0", a); end
            end else if (r < 91) begin
                @(negedge clk);
                for (int b = 0; b < N * W; b++) begin
                    p_out[b] = 1'($urandom_range(0, 1));
                    p_oeb[b] = 1'($urandom_range(0, 1));
                end
            end else if (r < 94) begin
                @(negedge clk);
                rst = 1;
                @(negedge clk);
                rst = 0;
            end
            repeat ($urandom_range(0, 14)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_switch();
        test_invalid_sel();
        test_restart();
        test_bus_reset();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/user_project_mux.md
Name: user_project_mux

Overview:
- Multi-project successor to the single-design user wrapper.
- Hosts N_PROJ user designs behind the Caravel IO pads and selects one at run time through a Wishbone control register.
- Switching between designs is glitch-safe. All pads are tri-stated for a guard interval, then the target design gets a held reset, and only then is its IO muxed onto the pads.
- Non-selected designs are held in reset.

Parameters:
- N_PROJ, 4: number of hosted designs (2..16).
- IO_W, 38: pad count (`MPRJ_IO_PADS).
- GUARD_CYCLES, 4: cycles of all-tristate before reset phase (>=1).
- RST_CYCLES, 8: cycles the target design's reset is held (>=1).
- BASE_ADDR, 32'h3000_0000: Wishbone base; block decodes adr[31:8]==BASE_ADDR[31:8].

Ports:
- wb_clk_i  in  1  single clock for block and all hosted designs.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; byte 0 is required for CTRL writes, other bytes are ignored.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- proj_io_out  in  N_PROJ*IO_W  per-design io_out, design k at [k*IO_W +: IO_W].
- proj_io_oeb  in  N_PROJ*IO_W  per-design io_oeb, same packing.
- proj_rst_o  out  N_PROJ  per-design synchronous reset, active-high.
- io_out  out  IO_W  to pads.
- io_oeb  out  IO_W  to pads (1 = input/tristate).
- active_o  out  1  high only in RUN.

Behaviour:
Reset:
- Synchronous on wb_rst_i.
- State=OFF; CTRL=0; ERR=0; wbs_ack_o=0; wbs_dat_o=0.
- proj_rst_o all ones; io_out=0; io_oeb all ones; active_o=0.

Wishbone:
- A request is hit = stb & cyc & address match & ~ack.
- ack is registered: high for exactly 1 cycle following the hit edge E.
- Non-matching addresses: no ack.
- wbs_dat_o is valid with ack and is 0 otherwise.
- Register map:
  - 0x00 CTRL (RW): [3:0] sel, [8] en.
  - 0x04 STATUS (RO except ERR): [1:0] state (OFF=0, GUARD=1, RESET=2, RUN=3), [11:8] active_sel, [16] ERR.
  - 0x08 CFG (RO): [7:0] N_PROJ, [15:8] GUARD_CYCLES, [23:16] RST_CYCLES.
- CTRL write with sel>=N_PROJ: CTRL is unchanged, ERR is set (sticky), and the write is still acked.
- Writing STATUS with bit16=1 clears ERR.
- Writes to other offsets are acked and have no effect.

FSM (target register tgt, counter cnt):
- OFF: all pads tristate, all resets high.
  - Accepted CTRL write with en=1 at edge E: tgt=sel, cnt=0, state=GUARD at E.
- GUARD: pads tristate, all resets high.
  - After GUARD_CYCLES cycles in GUARD: state=RESET, cnt=0.
- RESET: pads tristate; proj_rst_o[tgt] stays high.
  - After RST_CYCLES cycles: state=RUN, active_sel=tgt.
  - proj_rst_o[tgt] drops to 0 on entry to RUN.
- RUN:
  - io_out/io_oeb equal design active_sel's slices, combinationally muxed.
  - proj_rst_o = all ones except bit active_sel.
  - active_o=1.
- Exits from RUN:
  - CTRL write with en=0: state=OFF.
  - CTRL write with en=1 and sel!=active_sel: state=GUARD with the new tgt.
  - Rewrite of the same sel with en=1: no state change.
- Accepted CTRL write during GUARD or RESET: tgt updated, cnt=0, state=GUARD (the guard restarts); if en=0, state=OFF.
- Invalid-sel write in any state: no state change.
- Latency: write at E gives first RUN cycle at E + GUARD_CYCLES + RST_CYCLES.
- wb_rst_i in any state: returns to the reset values on the next edge and discards tgt.

Test Plan:
1. Reset then idle 20 cycles -> io_oeb=38'h3F_FFFF_FFFF, io_out=0, proj_rst_o=4'hF, STATUS read=0x0.
2. Write CTRL=0x102 (en=1, sel=2); design 2 drives io_out=38'h15_5555_5555, io_oeb=0 -> ack 1 cycle later. STATUS.state=1 for 4 cycles, then 2 for 8 cycles. At E+12: state=3, proj_rst_o=4'b1011, io_out=38'h15_5555_5555, io_oeb=0.
3. From RUN on sel 2, write CTRL=0x101 -> io_oeb all ones on the next cycle, proj_rst_o=4'hF. After 12 cycles RUN on sel 1, proj_rst_o=4'b1101.
4. Write CTRL=0x107 (sel invalid for N_PROJ=4) -> acked, state and active_sel unchanged, STATUS[16]=1. Write STATUS=0x10000 -> ERR=0.
5. Write sel=3 during RESET (cnt=5) -> state returns to GUARD, cnt restarts. RUN on sel 3 is reached exactly 12 cycles after that write. Design 0/1/2 resets stay high throughout.
6. Assert wb_rst_i for 1 cycle during RUN -> next edge: state=OFF, io_oeb all ones, proj_rst_o=4'hF, CTRL=0. Read of unmapped offset 0x0C -> ack, data 0.
